// File: rtl/score_bcd_ctrl.sv
// Score-to-BCD controller: frame-tick-triggered double-dabble, 5 registered digits.
// Optional leading-zero blank mask enabled by defining SCORE_LZ_BLANK_EN.
module score_bcd_ctrl #(
  parameter int SCORE_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score,
  input  logic               frame_tick,
  output logic [3:0]         dig_10000s,
  output logic [3:0]         dig_1000s,
  output logic [3:0]         dig_100s,
  output logic [3:0]         dig_10s,
  output logic [3:0]         dig_1s,
  output logic [4:0]         blank,
  output logic               busy,
  output logic               update
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(99999);

  state_t      state, next_state;
  logic [16:0] clamped, last_val, bin;
  logic [19:0] bcd, bcd_adj;
  logic [4:0]  cnt;
  logic        start, busy_d, update_d;

  // Full-width compare so bits above 17 still saturate the display.
  assign clamped = (score > MAX_SCORE) ? 17'd99999 : score[16:0];
  assign start   = (state == IDLE) && frame_tick && (clamped != last_val);

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (cnt == 5'd1) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_d   = (next_state != IDLE);
    update_d = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      update <= 1'b0;
    end else begin
      busy   <= busy_d;
      update <= update_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      last_val   <= '0;
      dig_10000s <= '0;
      dig_1000s  <= '0;
      dig_100s   <= '0;
      dig_10s    <= '0;
      dig_1s     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bin      <= clamped;
          bcd      <= '0;
          cnt      <= 5'd17;
          last_val <= clamped;
        end
        SHIFT: begin
          bcd <= {bcd_adj[18:0], bin[16]};
          bin <= {bin[15:0], 1'b0};
          cnt <= cnt - 5'd1;
        end
        DONE: begin
          dig_10000s <= bcd[19:16];
          dig_1000s  <= bcd[15:12];
          dig_100s   <= bcd[11:8];
          dig_10s    <= bcd[7:4];
          dig_1s     <= bcd[3:0];
        end
        default: ;
      endcase
    end
  end

`ifdef SCORE_LZ_BLANK_EN
  logic [4:0] lz;

  always_comb begin
    lz    = '0;
    lz[4] = (bcd[19:16] == 4'd0);
    lz[3] = lz[4] && (bcd[15:12] == 4'd0);
    lz[2] = lz[3] && (bcd[11:8] == 4'd0);
    lz[1] = lz[2] && (bcd[7:4] == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (reset)              blank <= 5'b11110;
    else if (state == DONE) blank <= lz;
  end
`else
  assign blank = 5'b00000;
`endif

endmodule

// File: tb/tb_score_bcd_ctrl.sv
// Directed bench for score_bcd_ctrl: latency, clamp, tick filtering, reset abort, blank mask.
module tb_score_bcd_ctrl;

  logic        clk = 1'b0;
  logic        reset, frame_tick, busy, update;
  logic [31:0] score;
  logic [3:0]  d4, d3, d2, d1, d0;
  logic [4:0]  blank;
  logic [19:0] digs;
  int          total = 0, bad = 0;

`ifdef SCORE_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  always #5 clk = ~clk;
  assign digs = {d4, d3, d2, d1, d0};

  score_bcd_ctrl #(.SCORE_W(32)) dut (
    .clk(clk), .reset(reset), .score(score), .frame_tick(frame_tick),
    .dig_10000s(d4), .dig_1000s(d3), .dig_100s(d2), .dig_10s(d1), .dig_1s(d0),
    .blank(blank), .busy(busy), .update(update)
  );

  function automatic logic [4:0] bx(input logic [4:0] v);
    return LZ ? v : 5'b00000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tick in cycle 0, busy cycles 1..18, results in cycle 19.
  // retick: extra tick (with score 11111) in that cycle; rst_at: reset in that cycle.
  task automatic conv(input string tag, input int s, input logic [19:0] exp_d,
                      input logic [4:0] exp_b, input int retick = 0, input int rst_at = 0);
    @(negedge clk); score = s; frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (c == rst_at) begin
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk({tag, "_abort_busy"}, busy, 0);
        chk({tag, "_abort_upd"}, update, 0);
        chk({tag, "_abort_digs"}, digs, 0);
        chk({tag, "_abort_blank"}, blank, bx(5'b11110));
        return;
      end
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_upd_early"}, update, 0);
      if (c == retick) begin score = 11111; frame_tick = 1'b1; end
      else frame_tick = 1'b0;
      @(negedge clk);
    end
    frame_tick = 1'b0;
    chk({tag, "_upd"}, update, 1);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_digs"}, digs, exp_d);
    chk({tag, "_blank"}, blank, exp_b);
    @(negedge clk);
    chk({tag, "_upd_pulse"}, update, 0);
  endtask

  // Optional tick, then require a quiet block with digits held.
  task automatic quiet(input string tag, input bit tick, input int s, input logic [19:0] exp_d);
    @(negedge clk); score = s; frame_tick = tick;
    @(negedge clk); frame_tick = 1'b0;
    for (int c = 0; c < 22; c++) begin
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_upd"}, update, 0);
      @(negedge clk);
    end
    chk({tag, "_digs"}, digs, exp_d);
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; score = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_upd", update, 0);
    chk("rst_digs", digs, 0);
    chk("rst_blank", blank, bx(5'b11110));
    reset = 1'b0;

    conv("s12345", 12345, 20'h12345, 5'b00000);
    conv("s200000", 200000, 20'h99999, 5'b00000);
    quiet("s150000_same", 1'b1, 150000, 20'h99999);
    conv("s777", 777, 20'h00777, bx(5'b11000));
    quiet("s777_same", 1'b1, 777, 20'h00777);
    conv("s0", 0, 20'h00000, bx(5'b11110));

    // Tick mid-conversion with a new score is dropped, not queued.
    conv("s54321", 54321, 20'h54321, 5'b00000, 5);
    quiet("s54321_noq", 1'b0, 11111, 20'h54321);
    conv("s11111", 11111, 20'h11111, 5'b00000);

    conv("s99999_rst", 99999, 20'h00000, 5'b00000, 0, 8);
    quiet("post_abort", 1'b0, 99999, 20'h00000);
    conv("s99999", 99999, 20'h99999, 5'b00000);

    conv("s42", 42, 20'h00042, bx(5'b11100));
    conv("s10005", 10005, 20'h10005, 5'b00000);
    conv("s0b", 0, 20'h00000, bx(5'b11110));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_bcd_ctrl.md
# score_bcd_ctrl

Sequential controller that converts the 32-bit game score into five BCD digits for the on-screen score text overlay. It replaces per-pixel divide/modulo logic with a multi-cycle double-dabble engine. Conversion is started only by the per-frame blanking tick, so digit values seen by the text renderer never change mid-frame. It sits between the score counter and the text overlay's character-code mux.

## Interface
- SCORE_W, 32, width of the input score (must be ≥ 17)
- clk  in  1  system/pixel clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; takes effect on the rising edge of clk
- score  in  SCORE_W  binary score from the game logic; may change at any time
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- dig_10000s, dig_1000s, dig_100s, dig_10s, dig_1s  out  4 each  registered BCD digits (0–9)
- blank  out  5  leading-zero blank mask; bit4 = 10000s … bit0 = 1s
- busy  out  1  high while a conversion is in progress
- update  out  1  one-cycle pulse when new digits are presented

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: on frame_tick, clamp score: values > 99999 become 99999 (17-bit result).
  - If the clamped value equals last_val, stay in IDLE. No busy, no update.
  - Otherwise load the clamped value into the 17-bit binary shift register. Clear the 20-bit BCD accumulator. Set cnt = 17. Store the value into last_val. Go to SHIFT.
- SHIFT, one bit per cycle:
  - Add 3 to every BCD nibble that is ≥ 5.
  - Then shift {bcd, bin} left by 1.
  - Decrement cnt. When cnt reaches 0 after a shift, go to DONE.
- DONE: copy the accumulator to the digit output registers, assert update for the following cycle, go to IDLE.
- frame_tick in SHIFT or DONE is ignored. There is no queuing. The next tick re-evaluates against last_val.
- score changes during a conversion do not affect the result, because the value was sampled at the tick.
- Digit outputs hold their value between updates. They change only on the DONE transition.
- Arithmetic:
  - Nibble adjust is 4-bit and cannot overflow, since nibbles are ≤ 9 before adjust.
  - The clamp compare uses the full SCORE_W width.
  - Upper score bits above 17 affect only the clamp.
- Reset values:
  - state = IDLE, busy = 0, update = 0.
  - All digits = 0, last_val = 0.
  - blank as per Configuration.
- Reset during SHIFT/DONE aborts the conversion. Digits return to 0 and no update is issued.

## Timing
- Cycle 0: frame_tick sampled high in IDLE with a changed value.
- Cycles 1–17: SHIFT, busy = 1.
- Cycle 18: DONE, busy = 1.
- Cycle 19: new digits and blank visible, update = 1, busy = 0.
- Latency from tick to valid digits: 19 cycles. This is far less than the vertical blanking period at any VGA mode.
- busy and update are registered outputs; there is no combinational path from inputs.
- A tick in cycle 19 or later starts a new conversion normally.

## Configuration
- SCORE_LZ_BLANK_EN defined:
  - blank[i] = 1 for each leading zero among the 10000s..10s digits, i.e. a digit is zero and all higher digits are zero.
  - blank[0] is always 0.
  - Registered and updated with the digits in DONE.
  - Reset value 5'b11110.
- SCORE_LZ_BLANK_EN undefined: blank is constant 5'b00000, and no mask logic is synthesized.

## Test plan
- Reset, then score = 12345 and frame_tick → cycles 1–18 busy = 1; cycle 19 digits 1,2,3,4,5, update = 1 for exactly one cycle.
- score = 200000 and tick → digits 9,9,9,9,9. A second tick with score = 150000 (also clamped to 99999) → no busy, no update.
- score = 777 converted; tick again with unchanged score → busy stays 0, digits stay 0,0,7,7,7. Change score to 0 and tick → digits 0,0,0,0,0 with update.
- Tick with score = 54321. Change score to 11111 and pulse frame_tick at cycle 5 → result 5,4,3,2,1 at cycle 19. No second conversion starts until the next tick.
- Reset asserted in SHIFT cycle 8 of converting 99999 → next cycle busy = 0, digits all 0, no update. The next tick with 99999 converts fully.
- With SCORE_LZ_BLANK_EN: score 42 → blank = 5'b11100. Score 0 → 5'b11110. Score 10005 → 5'b00000. Without the macro, blank = 0 in all cases.
